// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package seq_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ZDET = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIV  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_ERR   = 3;
  localparam int FLG_N     = 4;
endpackage

// File: rtl/seq_alu_addsub.sv
// Combinational ripple adder/subtractor; sub=1 computes a + ~b + 1.
module seq_alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  logic             cy;

  always_comb begin
    bx = sub ? ~b : b;
    cy = sub;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
    carry = cy;
    ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags, shift-add multiplier and,
// when SEQ_ALU_DIV_EN is defined, a restoring divider sharing the adder.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               err
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  op_t                op_q, op_d, op_e;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d, fin, step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLG_N-1:0]   flg_q, flg_d, fl;
  logic [WIDTH-1:0]   add_x, add_y, add_sum;
  logic               add_sub, add_c, add_v;
`ifdef SEQ_ALU_DIV_EN
  logic               ge;
`endif

  assign op_e = op_t'(op);

  seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(add_x), .b(add_y), .sub(add_sub), .sum(add_sum), .carry(add_c), .ovf(add_v)
  );

  // Adder is shared: live operands in IDLE, accumulator step in BUSY.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_sub = (op_e == OP_SUB);
    if (state_q == S_BUSY) begin
      add_x   = acc_q[2*WIDTH-1:WIDTH];
      add_y   = b_q;
      add_sub = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      if (op_q == OP_DIV) begin
        add_x   = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
        add_sub = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    fin     = '0;
    fl      = '0;
    step    = '0;
`ifdef SEQ_ALU_DIV_EN
    ge      = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d    = op_e;
        b_d     = b;
        acc_d   = {{WIDTH{1'b0}}, a};
        cnt_d   = '0;
        state_d = S_DONE;
        case (op_e)
          OP_ADD, OP_SUB: begin
            fin[WIDTH-1:0] = add_sum;
            fl[FLG_CARRY]  = add_c;
            fl[FLG_OVF]    = add_v;
          end
          OP_AND:  fin[WIDTH-1:0] = a & b;
          OP_OR:   fin[WIDTH-1:0] = a | b;
          OP_XOR:  fin[WIDTH-1:0] = a ^ b;
          OP_ZDET: fin[0] = (a == '0);
          OP_MUL:  state_d = S_BUSY;
`ifdef SEQ_ALU_DIV_EN
          OP_DIV:  state_d = S_BUSY;
`else
          OP_DIV:  fl[FLG_ERR] = 1'b1;
`endif
          default: ;
        endcase
        if (state_d == S_DONE) begin
          fl[FLG_ZERO] = (fin == '0);
          res_d = fin;
          flg_d = fl;
        end
      end
      S_BUSY: begin
        // MUL: acc = {partial product, multiplier}; shift right with adder carry.
        step = acc_q[0] ? {add_c, add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        // DIV: acc = {remainder, quotient}; a set top bit means the trial always fits.
        if (op_q == OP_DIV) begin
          ge   = acc_q[2*WIDTH-1] | add_c;
          step = {ge ? add_sum : add_x, acc_q[WIDTH-2:0], ge};
        end
`endif
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d          = S_DONE;
          res_d            = step;
          flg_d            = '0;
          flg_d[FLG_ZERO]  = (step == '0);
          flg_d[FLG_ERR]   = (op_q == OP_DIV) && (b_q == '0);
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign carry     = flg_q[FLG_CARRY];
  assign zero      = flg_q[FLG_ZERO];
  assign ovf       = flg_q[FLG_OVF];
  assign err       = flg_q[FLG_ERR];
endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_ready, out_valid, carry, zero, ovf, err;
  logic [2*W-1:0] result;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    bit          c, z, v, er;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0, cyc = 0, rdy_mode = 0;
  bit          seen = 0;
  logic [15:0] last_res = '0;
  logic [3:0]  last_fl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [2:0] o, logic [7:0] x, logic [7:0] y);
    exp_t e;
    int ux, uy, sx, sy, s;
    e = '{res: '0, c: 0, z: 0, v: 0, er: 0, lat: 1, acc: 0};
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    case (o)
      3'd0: begin
        s = ux + uy; e.res = 16'(s % 256); e.c = (s > 255);
        e.v = (sx + sy > 127) || (sx + sy < -128);
      end
      3'd1: begin
        e.res = 16'((ux - uy + 256) % 256); e.c = (ux >= uy);
        e.v = (sx - sy > 127) || (sx - sy < -128);
      end
      3'd2: e.res = {8'h00, x & y};
      3'd3: e.res = {8'h00, x | y};
      3'd4: e.res = {8'h00, x ^ y};
      3'd5: e.res = (ux == 0) ? 16'd1 : 16'd0;
      3'd6: begin e.res = 16'(ux * uy); e.lat = 9; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        e.lat = 9;
        if (uy == 0) begin e.res = {x, 8'hFF}; e.er = 1; end
        else e.res = 16'((ux % uy) * 256 + ux / uy);
`else
        e.er = 1;
`endif
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Every cycle: an accepted op must hold in_ready low and eventually present its result.
  always @(negedge clk) if (!reset) begin
    if (q.size() > 0 && cyc > q[0].acc) begin
      chk("busy_in_ready", in_ready, 0);
      if (out_valid) begin
        if (!seen) begin chk("latency", cyc - q[0].acc, q[0].lat); seen = 1; end
        chk("result", result, q[0].res);
        chk("flags", {carry, zero, ovf, err}, {q[0].c, q[0].z, q[0].v, q[0].er});
        if (out_ready) begin
          last_res = result;
          last_fl  = {carry, zero, ovf, err};
          void'(q.pop_front());
          seen = 0;
        end
      end
    end else begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(logic [2:0] o, logic [7:0] x, logic [7:0] y);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
      q.delete();
      seen = 0;
    end
  endtask

  task automatic dir(string n, logic [2:0] o, logic [7:0] x, logic [7:0] y,
                     logic [15:0] r, logic [3:0] f);
    exp_t m;
    m = model(o, x, y);
    chk({n, "_model_res"}, m.res, r);
    chk({n, "_model_flg"}, {m.c, m.z, m.v, m.er}, f);
    send(o, x, y);
    drain();
    chk({n, "_dut_res"}, last_res, r);
    chk({n, "_dut_flg"}, last_fl, f);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h7F;
      3: return 8'h80;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, ovf, err}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // flags order {carry, zero, ovf, err}
    dir("add_wrap", 3'd0, 8'd200, 8'd100, 16'h002C, 4'b1000);
    dir("sub_borrow", 3'd1, 8'd5, 8'd7, 16'h00FE, 4'b0000);
    dir("sub_ovf", 3'd1, 8'h80, 8'h01, 16'h007F, 4'b1010);
    dir("add_zero", 3'd0, 8'hFF, 8'h01, 16'h0000, 4'b1100);
    dir("and", 3'd2, 8'hF0, 8'h3C, 16'h0030, 4'b0000);
    dir("xor_zero", 3'd4, 8'h5A, 8'h5A, 16'h0000, 4'b0100);
    dir("mul_max", 3'd6, 8'hFF, 8'hFF, 16'hFE01, 4'b0000);
`ifdef SEQ_ALU_DIV_EN
    dir("div", 3'd7, 8'd200, 8'd7, 16'h041C, 4'b0000);
    dir("div_by0", 3'd7, 8'd9, 8'd0, 16'h09FF, 4'b0001);
`else
    dir("div_off", 3'd7, 8'd200, 8'd7, 16'h0000, 4'b0101);
`endif

    // Backpressure: result must hold while out_ready is low.
    rdy_mode = 2;
    send(3'd5, 8'd0, 8'd9);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1 rdy_mode = 0;
    drain();
    chk("zdet_hold_res", last_res, 16'h0001);
    chk("zdet_hold_flg", last_fl, 4'b0000);

    // Reset taken on the 4th multiply iteration discards the op.
    send(3'd6, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    seen = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {carry, zero, ovf, err}, 0);
    dir("add_after_rst", 3'd0, 8'd1, 8'd1, 16'h0002, 4'b0000);

    rdy_mode = 1;
    repeat (150) send(3'($urandom_range(0, 7)), pick(), pick());
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
